cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per source queue (power of two, >=2).
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 synchronous active-high reset; rdy input 1 global enable.
REQ-003 SHALL have ports: in_alu_tag input ROB_TAG_WIDTH (ALU result tag, ZERO_TAG_ROB = none); in_alu_value input DATA_WIDTH (ALU result).
REQ-004 SHALL have ports: in_lsb_tag input ROB_TAG_WIDTH (load result tag, ZERO_TAG_ROB = none); in_lsb_value input DATA_WIDTH (load result).
REQ-005 SHALL have port in_rob_misbranch input 1 (flush request).
REQ-006 SHALL have ports: out_cdb_tag output ROB_TAG_WIDTH (broadcast tag, ZERO_TAG_ROB = idle); out_cdb_value output DATA_WIDTH; out_cdb_src output 1 (0 = ALU, 1 = LSB).
REQ-007 SHALL have ports: out_alu_full output 1 and out_lsb_full output 1 (backpressure to the producer); out_overflow output 1 (sticky error flag).

Function
REQ-008 SHALL hold one FIFO per source, each FIFO_DEPTH entries of {tag, value}, with wrap-around read/write pointers and a count.
REQ-009 SHALL enqueue a source's result when rdy=1, the source tag is nonzero, and the FIFO is not full.
REQ-010 SHALL, on a nonzero tag presented to a full FIFO, drop the result and set out_overflow=1 until reset.
REQ-011 SHALL assert a source's full flag combinationally when its count >= FIFO_DEPTH-1, reserving one slot for the result already in flight.
REQ-012 SHALL broadcast at most one result per cycle from registered outputs; when no result is selected, out_cdb_tag SHALL be ZERO_TAG_ROB.
REQ-013 SHALL arbitrate round-robin between the two sources: a 1-bit last-grant register, the other source preferred on a tie, and the register updated only when a grant is made.
REQ-014 SHALL grant the only non-empty source regardless of the last-grant state.
REQ-015 SHALL keep the count unchanged, and advance both pointers, when a FIFO enqueues and dequeues in the same cycle.
REQ-016 SHALL allow both sources to enqueue in the same cycle as any dequeue.
REQ-017 SHALL, on in_rob_misbranch=1 with rdy=1, empty both FIFOs and drop both same-cycle inputs; out_cdb_tag SHALL be ZERO_TAG_ROB on the next cycle, with out_overflow and the last-grant register unchanged.
REQ-018 SHALL freeze all state and outputs when rdy=0 and ignore inputs presented during that cycle.

Reset
REQ-019 SHALL, when rst=1 at a clk edge (overrides rdy), set: out_cdb_tag=ZERO_TAG_ROB, out_cdb_value=0, out_cdb_src=0, pointers=0, counts=0, last-grant=LSB (ALU wins the first tie), out_overflow=0.
REQ-020 SHALL have out_alu_full=0 and out_lsb_full=0 while the FIFOs are empty after reset.

Configuration
REQ-021 SHALL support macro CDB_BYPASS_EN.
- Defined: when the granted source's FIFO is empty and the input tag is nonzero in this cycle, the input SHALL be broadcast on the next edge without being enqueued (latency 1).
- Undefined: every result SHALL be enqueued first (minimum latency 2 cycles from input to out_cdb_tag).
- Arbitration order SHALL be identical in both builds.

Structure
REQ-022 SHALL take ROB_TAG_WIDTH, DATA_WIDTH, ZERO_TAG_ROB, TRUE and FALSE from the shared constant.v definitions.
REQ-023 SHALL add a CDB_SRC_ALU/CDB_SRC_LSB encoding to that shared file.
REQ-024 SHALL instantiate one sub-module, cdb_fifo (parameterised depth/width, push/pop/flush, count, full), twice.

Verification
REQ-025 SHALL verify single ALU result: in_alu_tag=3, value=0x11 for one cycle -> out_cdb_tag=3, value=0x11, src=0 after 1 cycle (bypass) or 2 cycles (no bypass), then tag 0.
REQ-026 SHALL verify contention: ALU tags 1,2 and LSB tags 5,6 presented on two consecutive cycles after reset -> broadcast order 1,5,2,6 (ALU first), one per cycle.
REQ-027 SHALL verify backpressure: hold CDB busy via the other source and fill the ALU FIFO -> out_alu_full=1 at count 3 (depth 4); a 5th push sets out_overflow=1 and that tag never appears.
REQ-028 SHALL verify flush: 3 entries queued in each FIFO, then in_rob_misbranch=1 for one cycle -> out_cdb_tag=0 next cycle and no queued tag ever broadcast; a new ALU tag 7 afterwards broadcasts normally.
REQ-029 SHALL verify stall: rdy=0 for 3 cycles with entries queued -> outputs constant, inputs ignored; resumes the same order when rdy=1.
REQ-030 SHALL verify reset mid-operation: rst=1 with both FIFOs non-empty -> next cycle out_cdb_tag=0, full flags 0, overflow 0, queued tags lost.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB constants, source encoding and queue entry type
package cdb_arbiter_pkg;
  localparam int ROB_TAG_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {CDB_SRC_ALU = 1'b0, CDB_SRC_LSB = 1'b1} cdb_src_e;
  typedef struct packed {
    logic [ROB_TAG_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0] value;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer inputs and CDB broadcast outputs of cdb_arbiter
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;
  logic rdy;
  logic [ROB_TAG_WIDTH-1:0] in_alu_tag;
  logic [DATA_WIDTH-1:0] in_alu_value;
  logic [ROB_TAG_WIDTH-1:0] in_lsb_tag;
  logic [DATA_WIDTH-1:0] in_lsb_value;
  logic in_rob_misbranch;
  logic [ROB_TAG_WIDTH-1:0] out_cdb_tag;
  logic [DATA_WIDTH-1:0] out_cdb_value;
  logic out_cdb_src;
  logic out_alu_full;
  logic out_lsb_full;
  logic out_overflow;
  modport master (
    output rdy, in_alu_tag, in_alu_value, in_lsb_tag, in_lsb_value, in_rob_misbranch,
    input out_cdb_tag, out_cdb_value, out_cdb_src, out_alu_full, out_lsb_full, out_overflow
  );
  modport slave (
    input rdy, in_alu_tag, in_alu_value, in_lsb_tag, in_lsb_value, in_rob_misbranch,
    output out_cdb_tag, out_cdb_value, out_cdb_src, out_alu_full, out_lsb_full, out_overflow
  );
endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: circular result queue with flush; full_o raised one entry early
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= wdata_i;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q >= (AW+1)'(DEPTH - 1);
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin ALU/LSB result queues onto one registered CDB.
// Define CDB_BYPASS_EN to broadcast a result straight from the input when its queue is empty.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  cdb_arbiter_if.slave cdb_if
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(cdb_entry_t);
`ifdef CDB_BYPASS_EN
  localparam logic BYP = TRUE;
`else
  localparam logic BYP = FALSE;
`endif
  cdb_entry_t alu_in_e, lsb_in_e, alu_head, lsb_head, sel;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  logic alu_in, lsb_in, alu_ne, lsb_ne, alu_room, lsb_room, alu_av, lsb_av;
  logic gnt, gnt_lsb, alu_byp, lsb_byp, go, flush, ovf;
  logic alu_push, alu_pop, lsb_push, lsb_pop;
  cdb_src_e last_q, src_q;
  logic [ROB_TAG_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic ovf_q;
  always_comb begin
    alu_in_e = '{tag: cdb_if.in_alu_tag, value: cdb_if.in_alu_value};
    lsb_in_e = '{tag: cdb_if.in_lsb_tag, value: cdb_if.in_lsb_value};
    go = cdb_if.rdy & ~cdb_if.in_rob_misbranch;
    flush = cdb_if.rdy & cdb_if.in_rob_misbranch;
    alu_in = cdb_if.in_alu_tag != ZERO_TAG_ROB;
    lsb_in = cdb_if.in_lsb_tag != ZERO_TAG_ROB;
    alu_ne = alu_cnt != '0;
    lsb_ne = lsb_cnt != '0;
    alu_room = alu_cnt < CW'(FIFO_DEPTH);
    lsb_room = lsb_cnt < CW'(FIFO_DEPTH);
    alu_av = alu_ne | (BYP & alu_in);
    lsb_av = lsb_ne | (BYP & lsb_in);
    gnt = alu_av | lsb_av;
    gnt_lsb = (alu_av & lsb_av) ? (last_q == CDB_SRC_ALU) : lsb_av;
    alu_byp = BYP & gnt & ~gnt_lsb & ~alu_ne;
    lsb_byp = BYP & gnt_lsb & ~lsb_ne;
    sel = gnt_lsb ? (lsb_byp ? lsb_in_e : lsb_head) : (alu_byp ? alu_in_e : alu_head);
    alu_pop = go & gnt & ~gnt_lsb & alu_ne;
    lsb_pop = go & gnt_lsb & lsb_ne;
    alu_push = go & alu_in & alu_room & ~alu_byp;
    lsb_push = go & lsb_in & lsb_room & ~lsb_byp;
    ovf = go & ((alu_in & ~alu_room) | (lsb_in & ~lsb_room));
  end
  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_alu_fifo (
    .clk, .rst, .push_i(alu_push), .pop_i(alu_pop), .flush_i(flush), .wdata_i(alu_in_e),
    .rdata_o(alu_head), .count_o(alu_cnt), .full_o(cdb_if.out_alu_full)
  );
  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_lsb_fifo (
    .clk, .rst, .push_i(lsb_push), .pop_i(lsb_pop), .flush_i(flush), .wdata_i(lsb_in_e),
    .rdata_o(lsb_head), .count_o(lsb_cnt), .full_o(cdb_if.out_lsb_full)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= ZERO_TAG_ROB;
      value_q <= '0;
      src_q <= CDB_SRC_ALU;
      last_q <= CDB_SRC_LSB;
      ovf_q <= FALSE;
    end else if (cdb_if.rdy) begin
      tag_q <= go & gnt ? sel.tag : ZERO_TAG_ROB;
      value_q <= go & gnt ? sel.value : '0;
      src_q <= go & gnt_lsb ? CDB_SRC_LSB : CDB_SRC_ALU;
      last_q <= go & gnt ? (gnt_lsb ? CDB_SRC_LSB : CDB_SRC_ALU) : last_q;
      ovf_q <= ovf_q | ovf;
    end
  end
  assign cdb_if.out_cdb_tag = tag_q;
  assign cdb_if.out_cdb_value = value_q;
  assign cdb_if.out_cdb_src = src_q;
  assign cdb_if.out_overflow = ovf_q;
endmodule
